lmg_move_unpacker: RTL and testbench

Sits directly downstream of the legal move generator (LMG). It drains the LMG output FIFO of 160-bit words, each packing 8 moves of 19 bits. It discards invalid slots and presents one legal move per transfer to the search/eval stage over a valid/ready handshake. It also counts the moves in the list and signals when the list is exhausted.

---
 rtl/lmg_move_unpacker.sv | 138 +++++++++++++
 tb/tb_lmg_move_unpacker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lmg_move_unpacker.sv
// rtl/lmg_move_unpacker.sv - drains 8-slot LMG FIFO words into single legal moves over valid/ready.
// Optional castling/en-passant slot filtering is enabled with LMG_UNPACK_ENP_CAS_EN.
module lmg_move_unpacker #(
  parameter int SLOTS = 8,
  parameter int MV_W  = 19,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lmg_done,
  input  logic             fifo_empty,
  input  logic [159:0]     fifo_out,
`ifdef LMG_UNPACK_ENP_CAS_EN
  input  logic             lcas_flag,
  input  logic             rcas_flag,
  input  logic [7:0]       enp_flags,
`endif
  output logic             rden,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [5:0]       mv_from,
  output logic [5:0]       mv_to,
  output logic [5:0]       mv_flags,
  output logic [CNT_W-1:0] move_count,
  output logic             list_done,
  output logic             busy
);

  localparam int SEL_W = $clog2(SLOTS);
  localparam int FLD_W = MV_W - 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_DONE, S_ARM} state_t;

  state_t                      state_q, state_d;
  logic [SLOTS-1:0][FLD_W-1:0] word_q, word_d;
  logic [SLOTS-1:0]            pend_q, pend_d;
  logic [SLOTS-1:0]            slot_ok;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [SEL_W-1:0]            sel;
  logic                        any_pend;
  logic [FLD_W-1:0]            cur;
  logic                        unused_fifo_hi;

  assign unused_fifo_hi = ^fifo_out[159:SLOTS*MV_W];

  // Only bit 18 is dropped from the stored word; validity lives in the pending mask.
  always_comb begin
    slot_ok = '0;
    word_d  = word_q;
    for (int k = 0; k < SLOTS; k++) begin
      slot_ok[k] = ~fifo_out[(SLOTS-1-k)*MV_W + MV_W-1];
`ifdef LMG_UNPACK_ENP_CAS_EN
      if (fifo_out[(SLOTS-1-k)*MV_W + 16 +: 2] == 2'b01 && !lcas_flag) slot_ok[k] = 1'b0;
      if (fifo_out[(SLOTS-1-k)*MV_W + 16 +: 2] == 2'b10 && !rcas_flag) slot_ok[k] = 1'b0;
      if (fifo_out[(SLOTS-1-k)*MV_W + 15] && !enp_flags[fifo_out[(SLOTS-1-k)*MV_W +: 3]])
        slot_ok[k] = 1'b0;
`endif
      if (state_q == S_WAIT) word_d[k] = fifo_out[(SLOTS-1-k)*MV_W +: FLD_W];
    end
  end

  always_comb begin
    sel = '0;
    for (int k = SLOTS-1; k >= 0; k--) begin
      if (pend_q[k]) sel = k[SEL_W-1:0];
    end
  end

  assign any_pend   = |pend_q;
  assign cur        = word_q[sel];
  assign mv_valid   = (state_q == S_EMIT) && any_pend;
  assign mv_flags   = mv_valid ? cur[17:12] : 6'd0;
  assign mv_from    = mv_valid ? cur[11:6]  : 6'd0;
  assign mv_to      = mv_valid ? cur[5:0]   : 6'd0;
  assign move_count = cnt_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_ARM);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    rden      = 1'b0;
    list_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lmg_done) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!fifo_empty) begin
          rden    = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        pend_d  = slot_ok;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (!any_pend) begin
          state_d = S_REQ;
        end else if (mv_ready) begin
          pend_d[sel] = 1'b0;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          // Leaving on the last accept keeps the word-to-word bubble at REQ+WAIT.
          if (pend_d == '0) state_d = S_REQ;
        end
      end
      S_DONE: begin
        list_done = 1'b1;
        state_d   = S_ARM;
      end
      S_ARM: begin
        if (!lmg_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lmg_move_unpacker.sv
// tb/tb_lmg_move_unpacker.sv - scoreboard bench for lmg_move_unpacker with a FIFO model.
module tb_lmg_move_unpacker;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         lmg_done = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [159:0] fifo_out = '0;
  logic         mv_ready = 1'b0;
  logic         rden, mv_valid, list_done, busy;
  logic [5:0]   mv_from, mv_to, mv_flags;
  logic [7:0]   move_count;

  lmg_move_unpacker dut (
    .clk(clk), .reset(reset), .lmg_done(lmg_done), .fifo_empty(fifo_empty),
    .fifo_out(fifo_out),
`ifdef LMG_UNPACK_ENP_CAS_EN
    .lcas_flag(1'b1), .rcas_flag(1'b1), .enp_flags(8'hff),
`endif
    .rden(rden), .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_from(mv_from),
    .mv_to(mv_to), .mv_flags(mv_flags), .move_count(move_count),
    .list_done(list_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  logic [159:0] fifo_q[$];
  logic [17:0]  exp_q[$];
  int exp_n = 0;
  int rden_cnt = 0, ld_cnt = 0, ld_cyc = 0, xfer_cnt = 0;
  int stall_left = 0, stall_seen = 0;
  bit rdy_rand = 0, gap_track = 0, rd_pend = 0, prev_hold = 0;
  logic [17:0] prev_f;
  int idle_run = 0;
  int gaps[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: data appears on fifo_out the cycle after the read is sampled.
  always @(negedge clk) begin
    if (reset && rden) begin
      rden_cnt++;
      chk("rden_not_empty", {31'd0, fifo_empty}, 32'd0);
      rd_pend = 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rd_pend && fifo_q.size() > 0) begin
      fifo_out   = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
    rd_pend = 0;
  end

  // Monitor: drives mv_ready and checks each transfer that the next rising edge will take.
  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 0;
      mv_ready  = 1'b0;
    end else begin
      if (stall_left > 0 && mv_valid) begin
        mv_ready = 1'b0;
        stall_left--;
        stall_seen++;
        chk("stall_count", {24'd0, move_count}, 32'd0);
      end else begin
        mv_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (prev_hold) begin
        chk("hold_valid", {31'd0, mv_valid}, 32'd1);
        chk("hold_fields", {14'd0, mv_flags, mv_from, mv_to}, {14'd0, prev_f});
      end
      if (mv_valid && mv_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) chk("unexpected_move", {14'd0, mv_flags, mv_from, mv_to}, 32'hffffffff);
        else chk("move", {14'd0, mv_flags, mv_from, mv_to}, {14'd0, exp_q.pop_front()});
      end
      prev_hold = mv_valid && !mv_ready;
      prev_f    = {mv_flags, mv_from, mv_to};
      if (list_done) begin
        ld_cnt++;
        ld_cyc = cyc;
      end
      if (gap_track) begin
        if (mv_valid) begin
          if (idle_run > 0) gaps.push_back(idle_run);
          idle_run = 0;
        end else if (busy) begin
          idle_run++;
        end
      end
    end
  end

  function automatic logic [159:0] put_slot(input logic [159:0] w, input int k, input logic [18:0] s);
    logic [159:0] r;
    r = w;
    r[151-19*k -: 19] = s;
    return r;
  endfunction

  function automatic logic [159:0] rand_word(input int pct_valid);
    logic [159:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 8; k++)
      w = put_slot(w, k, {~($urandom_range(0, 99) < pct_valid), 18'($urandom)});
    return w;
  endfunction

  // Reference model: slots in index order, bit 18 clear means a legal move.
  task automatic add_word(input logic [159:0] w);
    logic [18:0] s;
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s = w[151-19*k -: 19];
      if (!s[18]) begin
        exp_q.push_back(s[17:0]);
        exp_n++;
      end
    end
  endtask

  task automatic run_list(input string name, input int nwords, input int hold);
    int start_ld, t, start_cyc;
    start_ld = ld_cnt;
    rden_cnt = 0;
    @(negedge clk);
    lmg_done  = 1'b1;
    start_cyc = cyc;
    t = 0;
    while (ld_cnt == start_ld && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_timeout"}, (t < 3000), 1);
    repeat (hold) @(negedge clk);
    lmg_done = 1'b0;
    repeat (3) @(negedge clk);
    chk({name, "_list_done_pulses"}, ld_cnt - start_ld, 1);
    chk({name, "_exp_drained"}, exp_q.size(), 0);
    chk({name, "_move_count"}, {24'd0, move_count}, (exp_n > 255) ? 255 : exp_n);
    chk({name, "_rden_pulses"}, rden_cnt, nwords);
    chk({name, "_idle_busy"}, {31'd0, busy}, 0);
    if (nwords == 0) chk({name, "_done_latency"}, ld_cyc - start_cyc, 2);
    exp_n = 0;
  endtask

  initial begin
    logic [159:0] w;
    int t;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rden, mv_valid, list_done, busy, mv_from, mv_to, mv_flags, move_count}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Two valid slots: 0 and 3.
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 8; k++) w = put_slot(w, k, {1'b1, 18'($urandom)});
    w = put_slot(w, 0, {1'b0, 6'o00, 6'o12, 6'o32});
    w = put_slot(w, 3, {1'b0, 6'o00, 6'o06, 6'o25});
    xfer_cnt = 0;
    add_word(w);
    run_list("two_slot", 1, 0);
    chk("two_slot_xfers", xfer_cnt, 2);

    // Three full words, back to back with ready held high.
    gap_track = 1; idle_run = 0; gaps.delete(); xfer_cnt = 0;
    for (int i = 0; i < 3; i++) add_word(rand_word(100));
    run_list("three_full", 3, 0);
    gap_track = 0;
    chk("three_full_xfers", xfer_cnt, 24);
    chk("three_full_gap_count", gaps.size(), 3);
    foreach (gaps[i]) chk("three_full_gap", gaps[i], 2);

    // Back-pressure on the first move.
    stall_seen = 0; stall_left = 5;
    add_word(rand_word(100));
    run_list("stall", 1, 0);
    chk("stall_cycles", stall_seen, 5);

    // Empty list, then lmg_done held high must not re-drain.
    run_list("empty", 0, 10);

    // All-invalid word then a single legal move.
    xfer_cnt = 0;
    add_word(rand_word(0));
    w = rand_word(0);
    w = put_slot(w, 5, {1'b0, 6'($urandom), 6'o64, 6'o44});
    add_word(w);
    run_list("invalid_then_one", 2, 0);
    chk("invalid_then_one_xfers", xfer_cnt, 1);

    // Randomised lists under random back-pressure.
    rdy_rand = 1;
    for (int l = 0; l < 6; l++) begin
      t = $urandom_range(1, 4);
      for (int i = 0; i < t; i++) add_word(rand_word($urandom_range(0, 100)));
      run_list("random", t, 0);
    end

    // Count saturation across 33 full words.
    rdy_rand = 0;
    for (int i = 0; i < 33; i++) add_word(rand_word(100));
    run_list("saturate", 33, 0);

    // Reset in the middle of a word.
    xfer_cnt = 0;
    add_word(rand_word(100));
    add_word(rand_word(100));
    t = ld_cnt;
    @(negedge clk);
    lmg_done = 1'b1;
    for (int i = 0; i < 200 && xfer_cnt < 3; i++) @(negedge clk);
    chk("mid_reset_reached", (xfer_cnt >= 3), 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_reset_outputs", {rden, mv_valid, list_done, busy, move_count}, 0);
    fifo_q.delete(); exp_q.delete(); exp_n = 0; fifo_empty = 1'b1;
    lmg_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_reset_no_list_done", ld_cnt - t, 0);
    chk("mid_reset_count", {24'd0, move_count}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
